// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: ALU op codes seen by the control unit and EX stage,
// plus the state encoding of the iterative multiplier.
package riscv_pkg;

  localparam logic [3:0] ALUOP_MUL   = 4'b0101;
  localparam logic [3:0] ALUOP_MULH  = 4'b0110;
  localparam logic [3:0] ALUOP_MULHU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALUOP_MUL) || (op == ALUOP_MULH) || (op == ALUOP_MULHU);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for mul/mulh/mulhu: WIDTH+2 cycles in EX (start, WIDTH steps, done).
// Holds the pipeline with stall_EX from the start cycle through the last step; no input backpressure.
module mul_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             stall_EX,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [3:0]         op;
  logic               neg;
  logic               is_mulh;
  logic               start;

  // Only mulh works on magnitudes; mul's low word and mulhu are unsigned products.
  always_comb begin
    is_mulh = (aluop == ALUOP_MULH);
    mag_a   = (is_mulh && a[WIDTH-1]) ? -a : a;
    mag_b   = (is_mulh && b[WIDTH-1]) ? -b : b;
    start   = rst_n && en && is_mul_op(aluop) && (state == IDLE);
    prod    = neg ? -acc : acc;
  end

  always_comb begin
    state_nxt    = state;
    stall_EX     = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          stall_EX  = 1'b1;
        end
      end
      BUSY: begin
        stall_EX = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        // The finished instruction is still on the inputs; never restart from here.
        state_nxt    = IDLE;
        result_valid = 1'b1;
        result       = (op == ALUOP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op     <= '0;
      neg    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            op     <= aluop;
            neg    <= is_mulh && (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_mul_unit;
  import riscv_pkg::*;

  localparam int W = 32;
  localparam logic [3:0] ALUOP_ADD = 4'b0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    aluop;
  logic [W-1:0]  a, b;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          stall_EX;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mul_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .aluop        (aluop),
    .a            (a),
    .b            (b),
    .result       (result),
    .result_valid (result_valid),
    .stall_EX     (stall_EX),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    up = longint'(x) * longint'(y);
    sp = longint'($signed(x)) * longint'($signed(y));
    case (op)
      ALUOP_MUL:   return up[31:0];
      ALUOP_MULH:  return sp[63:32];
      ALUOP_MULHU: return up[63:32];
      default:     return 32'h0;
    endcase
  endfunction

  // Drives one multiply from just after a rising edge, returns just after the DONE edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int stalls, output int cycles);
    bit got = 0;
    bit junk = 0;
    en = 1'b1; aluop = op; a = x; b = y;
    stalls = 0; cycles = 0; res = '0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      cycles++;
      if (stall_EX) stalls++;
      if (!result_valid && result != '0) junk = 1;
      if (result_valid) begin
        got = 1;
        res = result;
        chk("stall_low_in_done", stall_EX, 0);
      end
      @(posedge clk); #1;
    end
    chk("done_reached", got, 1);
    chk("result_zero_when_not_valid", junk, 0);
  endtask

  task automatic idle_check(input string tag, input int n);
    bit bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (stall_EX || busy || result_valid || result != '0) bad = 1;
      @(posedge clk); #1;
    end
    chk(tag, bad, 0);
  endtask

  logic [31:0] res;
  int          stalls, cycles;

  initial begin
    rst_n = 1'b0; en = 1'b0; aluop = ALUOP_ADD; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", stall_EX, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // mul 7 * -3
    run_op(ALUOP_MUL, 32'd7, 32'hFFFF_FFFD, res, stalls, cycles);
    chk("mul_7x-3", res, 32'hFFFF_FFEB);
    chk("mul_stall_cycles", stalls, W + 1);
    chk("mul_total_cycles", cycles, W + 2);
    en = 1'b0;
    idle_check("no_restart_after_done", 3);

    run_op(ALUOP_MULH, 32'h8000_0000, 32'h8000_0000, res, stalls, cycles);
    chk("mulh_min_sq", res, 32'h4000_0000);
    run_op(ALUOP_MULH, 32'hFFFF_FFFF, 32'd1, res, stalls, cycles);
    chk("mulh_-1x1", res, 32'hFFFF_FFFF);
    run_op(ALUOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, stalls, cycles);
    chk("mulhu_max_sq", res, 32'hFFFF_FFFE);
    run_op(ALUOP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, stalls, cycles);
    chk("mulh_-1x-1", res, 32'h0);
    en = 1'b0;
    idle_check("idle_after_directed", 2);

    // Back-to-back: second op starts the cycle after DONE.
    run_op(ALUOP_MUL, 32'd3, 32'd5, res, stalls, cycles);
    chk("b2b_first", res, 32'd15);
    run_op(ALUOP_MUL, 32'd6, 32'd7, res, stalls, cycles);
    chk("b2b_second", res, 32'd42);
    chk("b2b_second_cycles", cycles, W + 2);
    en = 1'b0;
    idle_check("b2b_only_two_pulses", 5);

    // Reset in BUSY cycle 10.
    begin
      bit seen_valid = 0;
      en = 1'b1; aluop = ALUOP_MUL; a = 32'd12345; b = 32'd678;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (result_valid) seen_valid = 1;
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      if (result_valid) seen_valid = 1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_stall", stall_EX, 0);
      chk("rst_mid_busy", busy, 0);
      for (int i = 0; i < W + 4; i++) begin
        @(negedge clk);
        if (result_valid || busy) seen_valid = 1;
      end
      chk("rst_no_partial_result", seen_valid, 0);
      @(posedge clk); #1;
    end
    run_op(ALUOP_MUL, 32'd2, 32'd2, res, stalls, cycles);
    chk("after_reset_2x2", res, 32'd4);

    // Non-multiply passes through; multiply with en=0 does not start.
    en = 1'b1; aluop = ALUOP_ADD; a = $urandom; b = $urandom;
    idle_check("add_no_stall", 4);
    en = 1'b0; aluop = ALUOP_MULH; a = $urandom; b = $urandom;
    idle_check("mul_en0_idle", 4);

    // Random ops, operands biased towards corner values.
    for (int t = 0; t < 24; t++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      logic [31:0] corners [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
      case ($urandom_range(0, 2))
        0: op = ALUOP_MUL;
        1: op = ALUOP_MULH;
        default: op = ALUOP_MULHU;
      endcase
      x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      run_op(op, x, y, res, stalls, cycles);
      chk($sformatf("rand%0d_op%0h_%h_%h", t, op, x, y), res, model(op, x, y));
      chk($sformatf("rand%0d_stalls", t), stalls, W + 1);
      if ($urandom_range(0, 1) == 0) begin
        en = 1'b0;
        idle_check($sformatf("rand%0d_idle", t), 1);
      end
    end

    en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multi-cycle multiplier in the EX stage, executing the RV32M subset decoded by the control unit (`mul`, `mulh`, `mulhu`, aluop 0101/0110/0111). It takes register operands alongside the ALU and generates `stall_EX` to hold the instruction in EX while the product is computed. `stall_EX` also gates `regwrite` in the control unit, so writeback occurs only in the completion cycle.

## Interface

Clock is `clk`. Reset is `rst_n`, synchronous and active-low. There is one clock domain.

Parameters:
- `WIDTH`, default 32: operand and result width. The product width is 2×WIDTH.

Ports:
- `clk`  input  1: system clock, rising edge.
- `rst_n`  input  1: synchronous active-low reset.
- `en`  input  1: EX holds a valid instruction.
- `aluop`  input  4: ALU operation code from the control unit.
- `a`  input  WIDTH: rs1 value.
- `b`  input  WIDTH: rs2 value.
- `result`  output  WIDTH: product word. Meaningful only while `result_valid` is high, and 0 otherwise.
- `result_valid`  output  1: pulse in the completion cycle.
- `stall_EX`  output  1: holds fetch and EX, and suppresses writeback.
- `busy`  output  1: FSM is not in IDLE.

## Operation

- A multiply op is `aluop` ∈ {0101 mul, 0110 mulh, 0111 mulhu}.
- A start condition is `en` && multiply op && state == IDLE.
- **IDLE state:**
  - On start, latch `a`, `b` and the op, and go to BUSY.
  - `stall_EX` is driven combinationally high in the start cycle.
  - Non-multiply ops pass through with `stall_EX` = 0.
- **BUSY state:**
  - Radix-2 shift-add on operand magnitudes, one multiplier bit per cycle.
  - The step counter runs 0..WIDTH−1. At count WIDTH−1, go to DONE.
  - `stall_EX` = 1 throughout.
- **DONE state:**
  - `stall_EX` = 0 and `result_valid` = 1. The pipeline advances at this edge.
  - The next state is always IDLE. The same instruction is still on the inputs during DONE, and it must not restart.
- **Signedness:**
  - `mulh`: the magnitudes of both operands are taken (|−2^31| = 0x8000_0000 as unsigned). The 2×WIDTH product is negated when sign(a) XOR sign(b).
  - `mulhu`: no conversion.
  - `mul`: the low word is identical for signed and unsigned. It is computed unsigned with no negation.
- **Result selection:**
  - `mul` takes product[WIDTH−1:0].
  - `mulh` and `mulhu` take product[2W−1:W].
- Inputs are ignored outside the start cycle.
- Reset mid-operation: at the next edge the block returns to IDLE, the product and counter are cleared, and `stall_EX` drops. A partial result is never emitted.

## Timing

- Reset values are `stall_EX`=0, `result_valid`=0, `result`=0 and `busy`=0. State is IDLE and the counter is 0.
- A multiply occupies EX for WIDTH+2 cycles (34 at default): 1 start cycle, WIDTH BUSY cycles, and 1 DONE cycle.
- `stall_EX` is high for WIDTH+1 consecutive cycles, from the start cycle through the last BUSY cycle.
- `result_valid` is high for exactly 1 cycle.
- Back-to-back multiplies: the second one starts in the cycle after DONE, with no idle gap beyond IDLE's start cycle.
- Non-multiply instructions see zero added latency.
- `en`=0 in IDLE with a multiply `aluop` does not start an operation.

## Structure

- Shared package `riscv_pkg` holds:
  - the aluop constants `ALUOP_MUL`=4'b0101, `ALUOP_MULH`=4'b0110 and `ALUOP_MULHU`=4'b0111;
  - the `mul_state_t` enum {IDLE, BUSY, DONE}.
- The control unit imports the same aluop constants.
- There is no sub-module. The FSM, counter and accumulator stay in one module of roughly 150 lines.

## Test plan

- `mul` with a=7, b=−3 (0xFFFFFFFD): stall_EX is high for 33 cycles, then result=0xFFFFFFEB with result_valid for 1 cycle.
- `mulh` with a=b=0x80000000: result=0x40000000. With `mulh` a=0xFFFFFFFF (−1), b=1: result=0xFFFFFFFF.
- `mulhu` with a=b=0xFFFFFFFF: result=0xFFFFFFFE. With `mulh` on the same operands: result=0x00000000.
- Back-to-back: `mul` 3×5, then `mul` 6×7 held on the inputs after DONE. Results are 15 then 42, with exactly two result_valid pulses and no restart from DONE.
- Assert `rst_n`=0 at BUSY cycle 10, held 1 cycle: stall_EX=0, busy=0 and result_valid never asserts. A new `mul` 2×2 afterwards returns 4.
- `add` with `en`=1: stall_EX stays 0 and busy stays 0. A `mul` aluop with `en`=0 stays in IDLE.
